// File: rtl/mux32_2x1_pkg.sv
// Shared datapath constants and types for the word-wide 2:1 selector.
package mux32_2x1_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

endpackage : mux32_2x1_pkg

// File: rtl/mux32_2x1_bit.sv
// One-bit 2:1 selector cell in AND/OR/NOT form.
module mux_bit_2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    logic s_n;
    logic pick_a;
    logic pick_b;
    logic agree;

    assign s_n    = ~s;
    assign pick_a = a & s_n;
    assign pick_b = b & s;
    // Consensus term: when a and b agree the output is defined even if s is unknown.
    assign agree  = a & b;
    assign y      = pick_a | pick_b | agree;

endmodule : mux_bit_2x1

// File: rtl/mux32_2x1.sv
// Word-wide 2:1 selector with a combinational output and a registered, valid-qualified copy.
module mux32_2x1
    import mux32_2x1_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic             Sel,
    input  logic             Vin,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             Vout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_bit_2x1 u_bit (
            .a (In0[i]),
            .b (In1[i]),
            .s (Sel),
            .y (Y[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Y_q  <= RESET_VAL;
            Vout <= 1'b0;
        end else begin
            Vout <= Vin;
            if (Vin) begin
                Y_q <= Y;
            end
        end
    end

endmodule : mux32_2x1

// File: tb/tb_mux32_2x1.sv
// Self-checking bench for mux32_2x1: vector table, directed sequences and random stimulus.
module tb_mux32_2x1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in0, in1;
    logic        sel, vin;
    logic [31:0] y, y_q;
    logic        vout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux32_2x1 dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .In0   (in0),
        .In1   (in1),
        .Sel   (sel),
        .Vin   (vin),
        .Y     (y),
        .Y_q   (y_q),
        .Vout  (vout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_y;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic s, input logic [31:0] a, input logic [31:0] b);
        return s ? b : a;
    endfunction

    initial begin
        vec_t        vecs[8];
        logic [31:0] exp_yq;
        logic        exp_vout;

        vecs[0] = '{32'h0000_03E8, 32'h0000_07CF, 1'b0, 32'h0000_03E8};
        vecs[1] = '{32'h0000_03E8, 32'h0000_07CF, 1'b1, 32'h0000_07CF};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hA5A5_A5A5};
        vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A};
        vecs[6] = '{32'h0000_002A, 32'h0000_002A, 1'b0, 32'h0000_002A};
        vecs[7] = '{32'h0000_002A, 32'h0000_002A, 1'b1, 32'h0000_002A};

        rst_n = 1'b0;
        in0 = '0; in1 = '0; sel = 1'b0; vin = 1'b0;
        #1;
        check("reset_yq", y_q, 32'h0);
        check("reset_vout", {31'b0, vout}, 32'h0);

        // combinational path, exercised while still in reset
        for (int i = 0; i < 8; i++) begin
            in0 = vecs[i].a; in1 = vecs[i].b; sel = vecs[i].s;
            #1;
            check($sformatf("table_y[%0d]", i), y, vecs[i].exp_y);
        end
        check("reset_hold_yq", y_q, 32'h0);

        in0 = 32'h0000_002A; in1 = 32'h0000_002A; sel = 1'bx;
        #1;
        check("selx_agree_y", y, 32'h0000_002A);
        sel = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;
        vin = 1'b1; sel = 1'b1; in1 = 32'h0000_0BAD; in0 = 32'h0000_1111;
        @(negedge clk);
        check("cap_yq", y_q, 32'h0000_0BAD);
        check("cap_vout", {31'b0, vout}, 32'h1);
        vin = 1'b0; sel = 1'b0; in0 = 32'h0000_7777;
        @(negedge clk);
        check("hold_yq", y_q, 32'h0000_0BAD);
        check("hold_vout", {31'b0, vout}, 32'h0);

        // random stream against a one-cycle-delay model
        exp_yq = 32'h0000_0BAD;
        exp_vout = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in0 = 32'($urandom_range(1999, 1));
            in1 = 32'($urandom_range(1999, 1));
            sel = 1'($urandom_range(1, 0));
            vin = 1'($urandom_range(1, 0));
            #1;
            check($sformatf("rand_y[%0d]", i), y, pick(sel, in0, in1));
            if (vin) exp_yq = pick(sel, in0, in1);
            exp_vout = vin;
            @(negedge clk);
            check($sformatf("rand_yq[%0d]", i), y_q, exp_yq);
            check($sformatf("rand_vout[%0d]", i), {31'b0, vout}, {31'b0, exp_vout});
        end

        // asynchronous reset mid-stream
        vin = 1'b1; sel = 1'b0; in0 = 32'h1234_5678;
        @(negedge clk);
        check("pre_rst_yq", y_q, 32'h1234_5678);
        in0 = 32'h0000_0055;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_yq", y_q, 32'h0);
        check("async_rst_vout", {31'b0, vout}, 32'h0);
        check("rst_y_tracks", y, 32'h0000_0055);
        sel = 1'b1; in1 = 32'h0000_0066;
        #1;
        check("rst_y_tracks_sel", y, 32'h0000_0066);
        @(negedge clk);
        check("rst_held_yq", y_q, 32'h0);
        check("rst_held_vout", {31'b0, vout}, 32'h0);

        rst_n = 1'b1;
        sel = 1'b0; in0 = 32'h0000_0ABC;
        @(negedge clk);
        check("first_cap_yq", y_q, 32'h0000_0ABC);
        check("first_cap_vout", {31'b0, vout}, 32'h1);

        // equal inputs: registered result independent of sel
        in0 = 32'hDEAD_BEEF; in1 = 32'hDEAD_BEEF; sel = 1'b1;
        @(negedge clk);
        check("equal_yq", y_q, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux32_2x1

// File: doc/mux32_2x1.md
Name: mux32_2x1

Overview:
- Word-wide 2:1 selector for the datapath (operand, writeback and PC-source selection).
- Provides a combinational output Y = Sel ? In1 : In0.
- Also provides a registered copy Y_q with a one-bit valid flag, for use where the select path must be pipelined.
- One clock domain; asynchronous active-low reset affects only the registered outputs.

Parameters:
- WIDTH, 32: data width of In0, In1, Y and Y_q.
- RESET_VAL, 0: value loaded into Y_q on reset (WIDTH bits).

Ports:
- Clk  input  1  rising-edge clock for the registered path.
- Rst_n  input  1  asynchronous active-low reset.
- In0  input  WIDTH  data selected when Sel=0.
- In1  input  WIDTH  data selected when Sel=1.
- Sel  input  1  select.
- Vin  input  1  input-valid qualifier for the registered path.
- Y  output  WIDTH  combinational mux result.
- Y_q  output  WIDTH  registered mux result.
- Vout  output  1  Y_q valid.

Interface decision:
- One clock (Clk).
- Reset (Rst_n) is asynchronous and active-low.

Behaviour:
- Combinational path:
  - Y = In0 when Sel=0; Y = In1 when Sel=1.
  - Zero latency; Y follows any input change within the same delta cycle.
  - Y is unaffected by Clk and Rst_n.
  - Y is valid during reset.
- Width rule:
  - Full WIDTH bits pass unmodified.
  - No sign or zero extension and no truncation; bit i of Y comes from bit i of the chosen input.
- Sel X/Z (simulation only):
  - Bits where In0 and In1 agree drive that value.
  - Differing bits drive X.
  - No default-to-In0 masking.
- Reset:
  - Rst_n low forces Y_q = RESET_VAL and Vout = 0 immediately, without waiting for Clk.
  - Both hold while Rst_n is low.
- Registered path, on each rising Clk with Rst_n high:
  - If Vin=1: Y_q <= (Sel ? In1 : In0) and Vout <= 1.
  - If Vin=0: Y_q holds its value and Vout <= 0.
  - Latency: exactly 1 cycle from sampled inputs to Y_q/Vout.
- No backpressure; every Vin=1 beat is accepted.
- Sel and data changes with Vin=0 do not disturb Y_q.
- Rst_n deassertion is synchronized externally. The first capture occurs on the first rising edge at which Rst_n is high.
- Reset asserted mid-stream clears Vout in the same cycle; the in-flight beat is discarded.
- Equal inputs (In0 == In1): Y and Y_q are independent of Sel.

Decomposition:
- Shared package holds:
  - DATA_W = 32 constant.
  - data_t typedef (logic [DATA_W-1:0]).
  - SEL_IN0 = 1'b0 and SEL_IN1 = 1'b1 constants.
- Sub-module mux_bit_2x1 (one-bit 2:1 cell, gate-level AND/OR/NOT form), instantiated WIDTH times via generate to build Y.
- Registered stage is an always_ff block in the top module.

Test Plan:
- In0=0x000003E8, In1=0x000007CF, Sel=0 -> Y=0x000003E8; Sel=1 -> Y=0x000007CF with no clock edge.
- In0=0xFFFFFFFF, In1=0x00000000, toggle Sel -> Y toggles full 32 bits (no partial-width selection); In0=0xA5A5A5A5/In1=0x5A5A5A5A same.
- Rst_n low mid-cycle with Y_q=0x12345678 -> Y_q=0, Vout=0 before next Clk edge; Y still tracks inputs.
- Vin=1, Sel=1, In1=0x00000BAD -> after 1 edge Y_q=0x00000BAD, Vout=1; next cycle Vin=0, Sel=0 -> Y_q stays 0x00000BAD, Vout=0.
- 16 random vectors, In0/In1 in 1..1999, random Sel, 10 ns apart -> Y equals the reference selection on every vector; Y_q equals the prior cycle's selection when Vin=1.
- In0=In1=0x0000002A with Sel=X -> Y=0x0000002A (no X propagation on agreeing bits).
